// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the nibble-serial ALU sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int unsigned NIBBLE_W = 4;

    // Add select already used by the alu_4bit bench.
    localparam logic [1:0] OP_ADD = 2'b10;

endpackage

// File: rtl/alu_nibble_seq.sv
// Drives an external 4-bit ALU one nibble at a time (LSB first), chaining carry
// between passes and returning the assembled wide result on a valid/ready port.
module alu_nibble_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned NIBBLES    = 4,
    parameter int unsigned SETTLE_CYC = 0,
    localparam int unsigned W         = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_a,
    input  logic [W-1:0] cmd_b,
    input  logic [1:0]   cmd_op,
    input  logic         cmd_cin,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_z,
    output logic         rsp_cout,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic         alu_cin,
    output logic [1:0]   alu_s_op,
    input  logic [3:0]   alu_z,
    input  logic         alu_cout
);

    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
    localparam logic [2:0]       SETTLE   = 3'(SETTLE_CYC);

    state_t                             state;
    logic [IDX_W-1:0]                   idx;
    logic [2:0]                         cnt;
    logic                               carry;
    logic [1:0]                         op_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   z_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
            rsp_cout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        a_q   <= cmd_a;
                        b_q   <= cmd_b;
                        op_q  <= cmd_op;
                        carry <= cmd_cin;
                        idx   <= '0;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Capture only in the final settle cycle of each nibble.
                    if (cnt == SETTLE) begin
                        cnt      <= '0;
                        z_q[idx] <= alu_z;
                        carry    <= alu_cout;
                        if (idx == LAST_IDX) begin
                            rsp_cout <= alu_cout;
                            state    <= DONE;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_z     = z_q;

    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        alu_s_op = '0;
        if (state == RUN) begin
            alu_a    = a_q[idx];
            alu_b    = b_q[idx];
            alu_cin  = carry;
            alu_s_op = op_q;
        end
    end

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Bench for alu_nibble_seq: two instances (SETTLE_CYC=0 and 2) each wired to a
// behavioural 4-bit ALU, checked every cycle against a wide-arithmetic model.
module tb_alu_nibble_seq;
    import alu_seq_pkg::*;

    localparam int unsigned N = 4;
    localparam int unsigned SET0 = 0;
    localparam int unsigned SET1 = 2;

    logic        clk;
    logic        rst       [2];
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [15:0] cmd_a     [2];
    logic [15:0] cmd_b     [2];
    logic [1:0]  cmd_op    [2];
    logic        cmd_cin   [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [15:0] rsp_z     [2];
    logic        rsp_cout  [2];
    logic [3:0]  alu_a     [2];
    logic [3:0]  alu_b     [2];
    logic        alu_cin   [2];
    logic [1:0]  alu_s_op  [2];
    logic [3:0]  alu_z     [2];
    logic        alu_cout  [2];

    int total = 0;
    int bad   = 0;
    bit run_chk = 0;

    // Behavioural stand-in for alu_4bit: 00 and, 01 or, 10 add, 11 a-b.
    function automatic logic [4:0] alu4(input logic [3:0] a, input logic [3:0] b,
                                        input logic cin, input logic [1:0] op);
        case (op)
            2'b00:   return {cin, a & b};
            2'b01:   return {cin, a | b};
            2'b10:   return {1'b0, a} + {1'b0, b} + {4'b0, cin};
            default: return {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
        endcase
    endfunction

    // Whole-word result over the low nbits; bit 16 is the carry out of that span.
    function automatic logic [16:0] ref_wide(input logic [15:0] a, input logic [15:0] b,
                                             input logic cin, input logic [1:0] op,
                                             input int unsigned nbits);
        logic [32:0] mask;
        logic [32:0] s;
        mask = (33'd1 << nbits) - 33'd1;
        case (op)
            2'b00:   return {cin, 16'({17'b0, a & b} & mask)};
            2'b01:   return {cin, 16'({17'b0, a | b} & mask)};
            2'b10:   s = ({17'b0, a} & mask) + ({17'b0, b} & mask) + {32'b0, cin};
            default: s = ({17'b0, a} & mask) + ({17'b0, ~b} & mask) + {32'b0, cin};
        endcase
        return {s[nbits], 16'(s & mask)};
    endfunction

    assign {alu_cout[0], alu_z[0]} = alu4(alu_a[0], alu_b[0], alu_cin[0], alu_s_op[0]);
    assign {alu_cout[1], alu_z[1]} = alu4(alu_a[1], alu_b[1], alu_cin[1], alu_s_op[1]);

    alu_nibble_seq #(.NIBBLES(N), .SETTLE_CYC(SET0)) dut0 (
        .clk(clk), .rst(rst[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_a(cmd_a[0]), .cmd_b(cmd_b[0]), .cmd_op(cmd_op[0]), .cmd_cin(cmd_cin[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_z(rsp_z[0]),
        .rsp_cout(rsp_cout[0]), .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_cin(alu_cin[0]),
        .alu_s_op(alu_s_op[0]), .alu_z(alu_z[0]), .alu_cout(alu_cout[0])
    );

    alu_nibble_seq #(.NIBBLES(N), .SETTLE_CYC(SET1)) dut1 (
        .clk(clk), .rst(rst[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_a(cmd_a[1]), .cmd_b(cmd_b[1]), .cmd_op(cmd_op[1]), .cmd_cin(cmd_cin[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_z(rsp_z[1]),
        .rsp_cout(rsp_cout[1]), .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_cin(alu_cin[1]),
        .alu_s_op(alu_s_op[1]), .alu_z(alu_z[1]), .alu_cout(alu_cout[1])
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int d, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[dut%0d]: got %0h want %0h at %0t", name, d, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 running (m_el cycles since accept), 2 result pending.
    int          m_phase [2];
    int unsigned m_el    [2];
    logic [15:0] m_a     [2];
    logic [15:0] m_b     [2];
    logic [1:0]  m_op    [2];
    logic        m_cin   [2];
    logic        m_zk    [2];
    logic [15:0] m_z     [2];
    logic        m_cout  [2];

    function automatic int unsigned settle_of(input int d);
        return (d == 0) ? SET0 : SET1;
    endfunction

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                m_phase[d] <= 0;
                m_el[d]    <= 0;
                m_zk[d]    <= 1'b1;
                m_z[d]     <= '0;
                m_cout[d]  <= 1'b0;
            end else if (m_phase[d] == 0) begin
                if (cmd_valid[d]) begin
                    m_phase[d] <= 1;
                    m_el[d]    <= 0;
                    m_a[d]     <= cmd_a[d];
                    m_b[d]     <= cmd_b[d];
                    m_op[d]    <= cmd_op[d];
                    m_cin[d]   <= cmd_cin[d];
                    m_zk[d]    <= 1'b0;
                end
            end else if (m_phase[d] == 1) begin
                m_el[d] <= m_el[d] + 1;
                if (m_el[d] + 1 == N * (settle_of(d) + 1)) begin
                    m_phase[d] <= 2;
                    m_zk[d]    <= 1'b1;
                    {m_cout[d], m_z[d]} <= ref_wide(m_a[d], m_b[d], m_cin[d], m_op[d], 16);
                end
            end else if (rsp_ready[d]) begin
                m_phase[d] <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run_chk) begin
            for (int d = 0; d < 2; d++) begin
                int unsigned k;
                logic [16:0] r;
                check("cmd_ready", d, cmd_ready[d], m_phase[d] == 0);
                check("rsp_valid", d, rsp_valid[d], m_phase[d] == 2);
                if (m_zk[d]) begin
                    check("rsp_z", d, rsp_z[d], m_z[d]);
                    check("rsp_cout", d, rsp_cout[d], m_cout[d]);
                end
                if (m_phase[d] == 1) begin
                    k = m_el[d] / (settle_of(d) + 1);
                    r = ref_wide(m_a[d], m_b[d], m_cin[d], m_op[d], 4 * k);
                    check("alu_a", d, alu_a[d], (m_a[d] >> (4 * k)) & 16'hF);
                    check("alu_b", d, alu_b[d], (m_b[d] >> (4 * k)) & 16'hF);
                    check("alu_cin", d, alu_cin[d], r[16]);
                    check("alu_s_op", d, alu_s_op[d], m_op[d]);
                end else begin
                    check("alu_idle", d, {alu_a[d], alu_b[d], alu_cin[d], alu_s_op[d]}, 0);
                end
            end
        end
    end

    logic [15:0] tr_cin;
    logic [3:0]  tr_a [16];

    task automatic issue(input int d, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] op, input logic cin);
        bit ok = 0;
        @(negedge clk); #1;
        cmd_valid[d] = 1; cmd_a[d] = a; cmd_b[d] = b; cmd_op[d] = op; cmd_cin[d] = cin;
        for (int i = 0; i < 100; i++) begin
            if (cmd_ready[d]) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        if (!ok) begin
            check("accept_timeout", d, 0, 1);
            cmd_valid[d] = 0;
            return;
        end
        @(posedge clk); #1;
        cmd_valid[d] = 0;
        cmd_a[d] = 16'($urandom); cmd_b[d] = 16'($urandom);
        cmd_op[d] = 2'($urandom); cmd_cin[d] = 1'($urandom);
    endtask

    task automatic collect(input int d, input int hold, output logic [15:0] z,
                           output logic c, output int lat);
        bit ok = 0;
        int n = 0;
        z = '0; c = 0; lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (rsp_valid[d]) begin ok = 1; break; end
            if (n <= 16) begin
                tr_cin[n-1] = alu_cin[d];
                tr_a[n-1]   = alu_a[d];
            end
        end
        if (!ok) begin
            check("rsp_timeout", d, 0, 1);
            return;
        end
        lat = n - 1;
        z = rsp_z[d];
        c = rsp_cout[d];
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_z", d, rsp_z[d], z);
            check("hold_cout", d, rsp_cout[d], c);
            check("hold_no_cmd", d, cmd_ready[d], 0);
        end
        #1 rsp_ready[d] = 1;
        @(posedge clk); #1;
        rsp_ready[d] = 0;
        @(negedge clk);
        check("ready_after_rsp", d, cmd_ready[d], 1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] z;
        logic        c;
        int          lat;
        logic [15:0] a, b;
        logic [1:0]  op;
        logic        ci;
        logic [16:0] r;
        logic [3:0]  exp_tr [12];
        exp_tr = '{4'h4, 4'h4, 4'h4, 4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h2, 4'h1, 4'h1, 4'h1};

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1; cmd_valid[d] = 0; cmd_a[d] = '0; cmd_b[d] = '0;
            cmd_op[d] = '0; cmd_cin[d] = 0; rsp_ready[d] = 0;
        end
        @(posedge clk);
        run_chk = 1;
        repeat (2) @(posedge clk);
        #1 rst[0] = 0; rst[1] = 0;

        @(negedge clk);
        check("reset_cmd_ready", 0, cmd_ready[0], 1);
        check("reset_rsp_valid", 0, rsp_valid[0], 0);
        check("reset_rsp_z", 0, rsp_z[0], 0);
        check("reset_alu_a", 0, alu_a[0], 0);

        issue(0, 16'h0002, 16'h0001, OP_ADD, 0);
        collect(0, 0, z, c, lat);
        check("basic_z", 0, z, 16'h0003);
        check("basic_cout", 0, c, 0);
        check("basic_latency", 0, lat, 4);

        issue(0, 16'hFFFF, 16'h0001, OP_ADD, 0);
        collect(0, 0, z, c, lat);
        check("ripple_z", 0, z, 16'h0000);
        check("ripple_cout", 0, c, 1);
        check("ripple_cin_trace", 0, tr_cin[3:0], 4'b1110);

        issue(0, 16'h00FF, 16'h0000, OP_ADD, 1);
        collect(0, 0, z, c, lat);
        check("cin_z", 0, z, 16'h0100);
        check("cin_cout", 0, c, 0);

        issue(0, 16'h1234, 16'h4321, OP_ADD, 0);
        collect(0, 5, z, c, lat);
        check("bp_z", 0, z, 16'h5555);

        // Abort while nibble 2 is on the ALU.
        issue(0, 16'hABCD, 16'h1111, OP_ADD, 0);
        repeat (3) @(negedge clk);
        #1 rst[0] = 1;
        @(posedge clk); #1;
        rst[0] = 0;
        @(negedge clk);
        check("abort_rsp_valid", 0, rsp_valid[0], 0);
        check("abort_cmd_ready", 0, cmd_ready[0], 1);
        check("abort_alu", 0, {alu_a[0], alu_b[0], alu_cin[0], alu_s_op[0]}, 0);
        issue(0, 16'h0011, 16'h0022, OP_ADD, 0);
        collect(0, 0, z, c, lat);
        check("after_abort_z", 0, z, 16'h0033);

        issue(1, 16'h1234, 16'h1111, OP_ADD, 0);
        collect(1, 0, z, c, lat);
        check("settle_z", 1, z, 16'h2345);
        check("settle_latency", 1, lat, 12);
        for (int i = 0; i < 12; i++) check("settle_alu_a_trace", 1, tr_a[i], exp_tr[i]);

        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 25; t++) begin
                a  = 16'($urandom);
                b  = 16'($urandom);
                op = 2'($urandom);
                ci = 1'($urandom);
                if (t % 5 == 0) op = OP_ADD;
                issue(d, a, b, op, ci);
                collect(d, int'($urandom_range(0, 3)), z, c, lat);
                r = ref_wide(a, b, ci, op, 16);
                check("rand_z", d, z, r[15:0]);
                check("rand_cout", d, c, r[16]);
                check("rand_latency", d, lat, N * (settle_of(d) + 1));
            end
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
